// File: rtl/dataflow_stat_monitor.sv
// ============================================================================
// Module   : dataflow_stat_monitor
// Brief    : Per-channel ap_ctrl handshake tracker with saturating statistics
//            and an optional deadlock watchdog (enable with DF_MON_DEADLOCK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dataflow_stat_monitor #(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = 32,
    parameter  int TIMEOUT = 1024,
    localparam int c_CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              clear,
    input  logic [c_CH_W-1:0] rd_ch,
    input  logic [1:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] busy,
    output logic              all_idle,
    output logic [NUM_CH-1:0] overflow,
    output logic              deadlock
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_BUSY = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  w_txn_a   [NUM_CH];
    logic [CNT_W-1:0]  w_last_a  [NUM_CH];
    logic [CNT_W-1:0]  w_max_a   [NUM_CH];
    logic [CNT_W-1:0]  w_stall_a [NUM_CH];
    logic [NUM_CH-1:0] w_cmpl;
    logic [CNT_W-1:0]  w_rd_val;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           r_state;
        state_t           w_next;
        logic [CNT_W-1:0] r_lat;
        logic [CNT_W-1:0] r_txn;
        logic [CNT_W-1:0] r_last;
        logic [CNT_W-1:0] r_max;
        logic [CNT_W-1:0] r_stall;
        logic [CNT_W-1:0] w_lat_done;
        logic             w_complete;
        logic             w_enter;
        logic             r_ovf;

        always_comb begin
            w_next     = r_state;
            w_complete = 1'b0;
            w_enter    = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ap_start[i]) begin
                        if (!ap_ready[i]) begin
                            w_next  = S_WAIT;
                            w_enter = 1'b1;
                        end else if (ap_done[i] && ap_continue[i]) begin
                            w_complete = 1'b1;
                        end else begin
                            w_next  = S_BUSY;
                            w_enter = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (ap_ready[i]) begin
                        if (ap_done[i] && ap_continue[i]) begin
                            w_complete = 1'b1;
                            w_next     = S_IDLE;
                        end else begin
                            w_next = S_BUSY;
                        end
                    end
                end
                S_BUSY, S_HOLD: begin
                    // In HOLD the done has already been seen; only continue matters.
                    if ((r_state == S_HOLD || ap_done[i]) && ap_continue[i]) begin
                        w_complete = 1'b1;
                        if (ap_start[i] && ap_ready[i]) begin
                            w_next  = S_BUSY;
                            w_enter = 1'b1;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end else if (ap_done[i]) begin
                        w_next = S_HOLD;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end

        // The accepting cycle counts as the first latency cycle.
        assign w_lat_done = (r_state == S_IDLE) ? c_ONE :
                            ((r_lat == c_MAX) ? c_MAX : r_lat + c_ONE);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_state <= S_IDLE;
                r_lat   <= '0;
                r_txn   <= '0;
                r_last  <= '0;
                r_max   <= '0;
                r_stall <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (!finish) begin
                    r_state <= w_next;
                    if (w_enter) begin
                        r_lat <= c_ONE;
                    end else if (r_state != S_IDLE && r_lat != c_MAX) begin
                        r_lat <= r_lat + c_ONE;
                    end
                end
                if (clear) begin
                    r_txn   <= '0;
                    r_last  <= '0;
                    r_max   <= '0;
                    r_stall <= '0;
                    r_ovf   <= 1'b0;
                end else if (!finish) begin
                    if (w_complete) begin
                        if (r_txn != c_MAX) begin
                            r_txn <= r_txn + c_ONE;
                        end
                        r_last <= w_lat_done;
                        if (w_lat_done > r_max) begin
                            r_max <= w_lat_done;
                        end
                    end
                    if (r_state == S_HOLD && r_stall != c_MAX) begin
                        r_stall <= r_stall + c_ONE;
                    end
                    if ((w_complete && r_txn == c_MAX) ||
                        (r_state == S_HOLD && r_stall == c_MAX) ||
                        (r_state != S_IDLE && r_lat == c_MAX)) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end

        assign busy[i]      = (r_state != S_IDLE);
        assign overflow[i]  = r_ovf;
        assign w_cmpl[i]    = w_complete;
        assign w_txn_a[i]   = r_txn;
        assign w_last_a[i]  = r_last;
        assign w_max_a[i]   = r_max;
        assign w_stall_a[i] = r_stall;
    end

    assign all_idle = ~|busy;

    always_comb begin
        w_rd_val = '0;
        if (int'(rd_ch) < NUM_CH) begin
            case (rd_sel)
                2'd0:    w_rd_val = w_txn_a[rd_ch];
                2'd1:    w_rd_val = w_last_a[rd_ch];
                2'd2:    w_rd_val = w_max_a[rd_ch];
                default: w_rd_val = w_stall_a[rd_ch];
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= w_rd_val;
        end
    end

`ifdef DF_MON_DEADLOCK_EN
    localparam int c_WD_W = $clog2(TIMEOUT + 1);

    logic [c_WD_W-1:0] r_wd;
    logic              r_deadlock;
    logic              w_wd_evt;

    assign w_wd_evt = (|(ap_start & ap_ready)) || (|w_cmpl);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wd       <= '0;
            r_deadlock <= 1'b0;
        end else if (clear) begin
            r_wd       <= '0;
            r_deadlock <= 1'b0;
        end else if (!finish) begin
            if (w_wd_evt || all_idle) begin
                r_wd <= '0;
            end else begin
                if (r_wd != c_WD_W'(TIMEOUT)) begin
                    r_wd <= r_wd + c_WD_W'(1);
                end
                if (r_wd >= c_WD_W'(TIMEOUT - 1)) begin
                    r_deadlock <= 1'b1;
                end
            end
        end
    end

    assign deadlock = r_deadlock;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{w_cmpl, (TIMEOUT > 0)};
    assign deadlock     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dataflow_stat_monitor.sv
// ============================================================================
// Module   : tb_dataflow_stat_monitor
// Brief    : Directed bench: a 32-bit and a 4-bit/3-channel monitor share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dataflow_stat_monitor;

    logic        clock;
    logic        reset;
    logic [3:0]  ap_start, ap_ready, ap_done, ap_continue;
    logic        finish, clear;
    logic [1:0]  rd_ch, rd_sel;

    logic [31:0] rd_data;
    logic [3:0]  busy, overflow;
    logic        all_idle, deadlock;

    logic [3:0]  rd_data4;
    logic [2:0]  busy4, overflow4;
    logic        all_idle4, deadlock4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ch;
        int          sel;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    dataflow_stat_monitor #(.NUM_CH(4), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish), .clear(clear),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data),
        .busy(busy), .all_idle(all_idle), .overflow(overflow), .deadlock(deadlock)
    );

    dataflow_stat_monitor #(.NUM_CH(3), .CNT_W(4), .TIMEOUT(8)) dut4 (
        .clock(clock), .reset(reset),
        .ap_start(ap_start[2:0]), .ap_ready(ap_ready[2:0]), .ap_done(ap_done[2:0]),
        .ap_continue(ap_continue[2:0]), .finish(finish), .clear(clear),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data4),
        .busy(busy4), .all_idle(all_idle4), .overflow(overflow4), .deadlock(deadlock4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic rdchk(input string name, input int ch, input int sel, input logic [31:0] exp);
        rd_ch  = 2'(ch);
        rd_sel = 2'(sel);
        step();
        chk(name, rd_data, exp);
    endtask

    task automatic rdchk4(input string name, input int ch, input int sel, input logic [3:0] exp);
        rd_ch  = 2'(ch);
        rd_sel = 2'(sel);
        step();
        chk(name, {28'd0, rd_data4}, {28'd0, exp});
    endtask

    task automatic idle_inputs();
        ap_start    = 4'h0;
        ap_ready    = 4'h0;
        ap_done     = 4'h0;
        ap_continue = 4'hF;
        finish      = 1'b0;
        clear       = 1'b0;
    endtask

    initial begin
        // Expected statistics after the ch0..ch3 scenarios: txn, last, max, stall.
        tbl[0]  = '{0, 0, 32'd1}; tbl[1]  = '{0, 1, 32'd6};
        tbl[2]  = '{0, 2, 32'd6}; tbl[3]  = '{0, 3, 32'd0};
        tbl[4]  = '{1, 0, 32'd2}; tbl[5]  = '{1, 1, 32'd2};
        tbl[6]  = '{1, 2, 32'd7}; tbl[7]  = '{1, 3, 32'd3};
        tbl[8]  = '{2, 0, 32'd2}; tbl[9]  = '{2, 1, 32'd3};
        tbl[10] = '{2, 2, 32'd4}; tbl[11] = '{2, 3, 32'd0};
        tbl[12] = '{3, 0, 32'd2}; tbl[13] = '{3, 1, 32'd3};
        tbl[14] = '{3, 2, 32'd3}; tbl[15] = '{3, 3, 32'd0};

        reset  = 1'b0;
        rd_ch  = 2'd0;
        rd_sel = 2'd0;
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_busy", {28'd0, busy}, 32'd0);
        chk("rst_all_idle", {31'd0, all_idle}, 32'd1);
        chk("rst_overflow", {28'd0, overflow}, 32'd0);
        chk("rst_deadlock", {31'd0, deadlock}, 32'd0);
        reset = 1'b1;
        step();
        for (int k = 0; k < 16; k++)
            rdchk($sformatf("rst_stat_ch%0d_sel%0d", k / 4, k % 4), k / 4, k % 4, 32'd0);

        // ch0: accept at cycle 0, complete at cycle 5
        rd_ch = 2'd0; rd_sel = 2'd0;
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        step();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("busyA_c%0d", c), {28'd0, busy}, 32'h1);
            if (c < 5) step();
        end
        ap_done[0] = 1'b1;
        step();
        ap_done[0] = 1'b0;
        chk("rd_same_cycle_old", rd_data, 32'd0);
        chk("A_all_idle", {31'd0, all_idle}, 32'd1);
        step();
        chk("rd_next_cycle_new", rd_data, 32'd1);

        // ch1: done held three cycles with continue low, then short transaction
        ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
        step();
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
        step(); step();
        ap_done[1] = 1'b1; ap_continue[1] = 1'b0;
        step();
        chk("B_hold_busy", {28'd0, busy}, 32'h2);
        step(); step();
        ap_continue[1] = 1'b1;
        step();
        ap_done[1] = 1'b0;
        chk("B_idle_after_hold", {28'd0, busy}, 32'h0);
        ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
        step();
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0; ap_done[1] = 1'b1;
        step();
        ap_done[1] = 1'b0;

        // ch2: back-to-back completion with new acceptance
        ap_start[2] = 1'b1; ap_ready[2] = 1'b1;
        step();
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
        step(); step();
        ap_start[2] = 1'b1; ap_ready[2] = 1'b1; ap_done[2] = 1'b1;
        step();
        ap_start[2] = 1'b0; ap_ready[2] = 1'b0; ap_done[2] = 1'b0;
        chk("C_b2b_busy", {28'd0, busy}, 32'h4);
        step();
        ap_done[2] = 1'b1;
        step();
        ap_done[2] = 1'b0;

        // ch3: single-cycle transaction from IDLE, then one through WAIT_READY
        ap_start[3] = 1'b1; ap_ready[3] = 1'b1; ap_done[3] = 1'b1;
        step();
        ap_ready[3] = 1'b0; ap_done[3] = 1'b0;
        chk("C_zero_lat_idle", {28'd0, busy}, 32'h0);
        step();
        chk("C_wait_busy", {28'd0, busy}, 32'h8);
        ap_ready[3] = 1'b1;
        step();
        ap_start[3] = 1'b0; ap_ready[3] = 1'b0; ap_done[3] = 1'b1;
        step();
        ap_done[3] = 1'b0;

        for (int k = 0; k < 16; k++)
            rdchk($sformatf("stat_ch%0d_sel%0d", tbl[k].ch, tbl[k].sel), tbl[k].ch, tbl[k].sel, tbl[k].exp);
        chk("stat_overflow", {28'd0, overflow}, 32'd0);
        rdchk4("rd_out_of_range", 3, 0, 4'd0);

        // Saturation: 16 single-cycle transactions on ch0
        clear = 1'b1;
        step();
        clear = 1'b0;
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1; ap_done[0] = 1'b1;
        repeat (16) step();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0; ap_done[0] = 1'b0;
        chk("sat_overflow4", {29'd0, overflow4}, 32'h1);
        chk("sat_overflow32", {28'd0, overflow}, 32'h0);
        rd_ch = 2'd0; rd_sel = 2'd0;
        step();
        chk("sat_txn4", {28'd0, rd_data4}, 32'd15);
        chk("sat_txn32", rd_data, 32'd16);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_overflow4", {29'd0, overflow4}, 32'h0);
        rdchk4("clr_txn4", 0, 0, 4'd0);
        rdchk("clr_last32", 0, 1, 32'd0);

        // Completion and clear in the same cycle
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        step();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0; ap_done[0] = 1'b1; clear = 1'b1;
        step();
        ap_done[0] = 1'b0; clear = 1'b0;
        chk("clrcmp_idle", {28'd0, busy}, 32'h0);
        rdchk("clrcmp_txn", 0, 0, 32'd0);
        rdchk("clrcmp_last", 0, 1, 32'd0);

        // Reset in the middle of a ch1 transaction
        ap_start[1] = 1'b1; ap_ready[1] = 1'b1;
        step();
        ap_start[1] = 1'b0; ap_ready[1] = 1'b0;
        step();
        chk("midrst_busy_before", {28'd0, busy}, 32'h2);
        reset = 1'b0;
        #2;
        chk("midrst_busy_async", {28'd0, busy}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        ap_done[1] = 1'b1;
        step();
        ap_done[1] = 1'b0;
        rdchk("midrst_no_count", 1, 0, 32'd0);

        // Watchdog and finish freeze on ch0
        ap_start[0] = 1'b1; ap_ready[0] = 1'b1;
        step();
        ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
        repeat (7) step();
`ifdef DF_MON_DEADLOCK_EN
        chk("wd_before_timeout", {31'd0, deadlock4}, 32'd0);
`endif
        finish = 1'b1;
        repeat (3) step();
        chk("finish_busy_held", {28'd0, busy}, 32'h1);
        finish = 1'b0;
`ifdef DF_MON_DEADLOCK_EN
        chk("wd_paused_by_finish", {31'd0, deadlock4}, 32'd0);
        step();
        chk("wd_timeout", {31'd0, deadlock4}, 32'd1);
`else
        step();
        chk("wd_absent4", {31'd0, deadlock4}, 32'd0);
`endif
        chk("wd_long_timeout", {31'd0, deadlock}, 32'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("wd_cleared", {31'd0, deadlock4}, 32'd0);
        ap_done[0] = 1'b1;
        step();
        ap_done[0] = 1'b0;
        rdchk("finish_froze_latency", 0, 1, 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dataflow_stat_monitor.md
# dataflow_stat_monitor

Synthesizable, parametrised successor to the simulation-only dataflow status monitor. Observes the ap_start/ap_ready/ap_done/ap_continue handshakes of NUM_CH kernel channels and tracks each channel's transaction state. Accumulates per-channel statistics (transaction count, last and maximum latency, stall cycles) readable over a registered select port. Sits beside the top-level kernel in both simulation and on-chip debug builds.

## Interface
- NUM_CH, 4: number of monitored channels (1..16)
- CNT_W, 32: width of every statistic counter
- TIMEOUT, 1024: deadlock watchdog threshold in cycles (used only with DF_MON_DEADLOCK_EN)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ap_start  in  NUM_CH  per-channel start
- ap_ready  in  NUM_CH  per-channel ready
- ap_done  in  NUM_CH  per-channel done
- ap_continue  in  NUM_CH  per-channel continue; tie high for ap_ctrl_hs channels
- finish  in  1  freezes all FSMs and counters while high
- clear  in  1  synchronous clear of all statistics and sticky flags
- rd_ch  in  $clog2(NUM_CH) (min 1)  channel select
- rd_sel  in  2  0=txn_count, 1=last_latency, 2=max_latency, 3=stall_cycles
- rd_data  out  CNT_W  registered selected statistic
- busy  out  NUM_CH  channel FSM not IDLE
- all_idle  out  1  all channels IDLE
- overflow  out  NUM_CH  sticky: a counter of that channel saturated
- deadlock  out  1  sticky watchdog flag

## Operation
- Per-channel FSM: IDLE, WAIT_READY, BUSY, HOLD.
- IDLE: start&!ready -> WAIT_READY; start&ready -> BUSY; start&ready&done&continue same cycle -> completion with latency 1, stay IDLE.
- WAIT_READY: ready -> BUSY (if done&continue also high: completion, -> IDLE).
- BUSY: done&continue -> completion; next state BUSY if start&ready that cycle, else IDLE. done&!continue -> HOLD.
- HOLD: stall_cycles += 1 each cycle; continue -> completion, then as BUSY rule.
- lat_cnt: cleared at transaction entry (leaving IDLE), +1 each non-IDLE cycle; at completion last_latency = lat_cnt+1, max_latency updated if greater, txn_count += 1.
- All counters saturate at 2^CNT_W-1; saturation sets overflow[ch].
- clear: priority over every update; zeroes statistics, overflow, deadlock; FSM state untouched.
- finish=1: FSMs, counters and watchdog hold; rd port still operates.
- rd_ch >= NUM_CH returns 0.

## Timing
- Reset (async assert, sync-safe deassert): all FSMs IDLE, all counters 0, rd_data=0, busy=0, all_idle=1, overflow=0, deadlock=0.
- busy/all_idle combinational from FSM state registers (zero-cycle from state).
- rd_data: 1-cycle latency; reflects statistics as registered at the sampling edge (an update in the same cycle is not visible until next read).
- Completion and clear in same cycle: clear wins, statistic stays 0.
- Reset mid-transaction: transaction discarded, no count.

## Configuration
- DF_MON_DEADLOCK_EN defined: watchdog counter increments each cycle any channel is non-IDLE and no channel accepts (start&ready) or completes; any such event zeroes it; reaching TIMEOUT sets deadlock (sticky until clear/reset); frozen by finish.
- Undefined: watchdog logic absent, deadlock tied 0, TIMEOUT unused.

## Test plan
- Reset then idle: rd_data=0 for all rd_ch/rd_sel, all_idle=1, busy=0.
- Ch0: start&ready at cycle 0, done&continue at cycle 5 -> txn_count=1, last_latency=6, max_latency=6, busy[0] high cycles 1-5.
- Ch1 done held 3 cycles with continue low -> stall_cycles=3; second shorter transaction -> max_latency keeps first value.
- Back-to-back: completion with start&ready same cycle on ch2 -> stays BUSY, two transactions counted; zero-latency case in IDLE -> latency 1.
- CNT_W=4, 16 transactions on ch0 -> txn_count=15, overflow[0]=1; clear -> all 0, overflow 0.
- With DF_MON_DEADLOCK_EN, TIMEOUT=8: ch0 BUSY, no events 8 cycles -> deadlock=1; pulse finish meanwhile -> count pauses.
